bitwise_alu: RTL and testbench

BITWISE_ALU -- requirements
Module: bitwise_alu

---
 rtl/bitwise_alu.sv | 95 +++++++++
 tb/tb_bitwise_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_alu.sv
// Bitwise ALU (NOT/AND/OR/XOR/NAND/NOR/XNOR/pass) feeding a FIFO_DEPTH-entry result buffer.
// One-cycle latency into an empty buffer; in_ready drops when full, and no input reaches any output combinationally.
module bitwise_alu #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic            live_q;
  logic [WIDTH-1:0] res;
  entry_t          wr_entry;
  entry_t          head;
  logic            push, pop;

  always_comb begin
    res = in_a;
    case (in_op)
      3'b000:  res = ~in_a;
      3'b001:  res = in_a & in_b;
      3'b010:  res = in_a | in_b;
      3'b011:  res = in_a ^ in_b;
      3'b100:  res = ~(in_a & in_b);
      3'b101:  res = ~(in_a | in_b);
      3'b110:  res = ~(in_a ^ in_b);
      default: res = in_a;
    endcase
  end

  assign wr_entry.data = res;
  assign wr_entry.zr   = ~|res;
  assign wr_entry.ng   = res[WIDTH-1];

  // live_q keeps in_ready low through reset and for the edge it is released on
  assign in_ready  = live_q && (count_q < CW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (push) wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    if (pop)  rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      live_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      live_q  <= 1'b1;
      if (push) mem_q[wptr_q] <= wr_entry;
    end
  end

  assign head     = mem_q[rptr_q];
  assign out_data = out_valid ? head.data : '0;
  assign out_zr   = out_valid & head.zr;
  assign out_ng   = out_valid & head.ng;

endmodule

// File: tb/tb_bitwise_alu.sv
// Directed bench for bitwise_alu: default instance (16-bit, depth 2) plus an 8-bit depth-4 instance.
module tb_bitwise_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zr, out_ng;
  logic [2:0]  in_op;
  logic [15:0] in_a, in_b, out_data;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_zr2, out_ng2;
  logic [2:0]  in_op2;
  logic [7:0]  in_a2, in_b2, out_data2;

  int checks = 0;
  int fails  = 0;

  bitwise_alu #(.WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zr(out_zr), .out_ng(out_ng)
  );

  bitwise_alu #(.WIDTH(8), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_zr(out_zr2), .out_ng(out_ng2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks required completion", checks);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; presents one request and returns at the negedge after it is accepted.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if ({out_data, out_zr, out_ng} !== 18'h0) begin fails++; $display("FAIL reset_outputs got %h/%b/%b exp 0", out_data, out_zr, out_ng); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL release_in_ready_before_edge got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready_after_edge got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_not();
    out_ready = 1'b1;
    drive(3'b000, 16'h0000, 16'h5A5A);
    checks++; if ({out_valid, out_data, out_zr, out_ng} !== {1'b1, 16'hFFFF, 1'b0, 1'b1})
      begin fails++; $display("FAIL not_0000 got v=%b %h zr=%b ng=%b exp v=1 ffff zr=0 ng=1", out_valid, out_data, out_zr, out_ng); end
    drive(3'b000, 16'h1234, 16'hFFFF);
    checks++; if ({out_valid, out_data, out_zr, out_ng} !== {1'b1, 16'hEDCB, 1'b0, 1'b1})
      begin fails++; $display("FAIL not_1234 got v=%b %h zr=%b ng=%b exp v=1 edcb zr=0 ng=1", out_valid, out_data, out_zr, out_ng); end
    @(negedge clk);
    checks++; if ({out_valid, out_data} !== 17'h0) begin fails++; $display("FAIL empty_after_pop got v=%b %h exp 0", out_valid, out_data); end
  endtask

  task automatic test_all_ops();
    logic [15:0] exp_tab [8];
    exp_tab[0] = 16'hC33C; exp_tab[1] = 16'h2882; exp_tab[2] = 16'hBEEB; exp_tab[3] = 16'h9669;
    exp_tab[4] = 16'hD77D; exp_tab[5] = 16'h4114; exp_tab[6] = 16'h6996; exp_tab[7] = 16'h3CC3;
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      drive(3'(op), 16'h3CC3, 16'hAAAA);
      checks++; if ({out_valid, out_data, out_zr, out_ng} !== {1'b1, exp_tab[op], 1'b0, exp_tab[op][15]})
        begin fails++; $display("FAIL op%0d got v=%b %h zr=%b ng=%b exp %h", op, out_valid, out_data, out_zr, out_ng, exp_tab[op]); end
    end
    drive(3'b001, 16'hAAAA, 16'h5555);
    checks++; if ({out_valid, out_data, out_zr, out_ng} !== {1'b1, 16'h0000, 1'b1, 1'b0})
      begin fails++; $display("FAIL and_zero got v=%b %h zr=%b ng=%b exp 0000 zr=1 ng=0", out_valid, out_data, out_zr, out_ng); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b011; in_a = 16'h00FF; in_b = 16'h0F0F;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_one got %b exp 1", in_ready); end
    in_op = 3'b010; in_a = 16'h1100; in_b = 16'h0011;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
    checks++; if (out_data !== 16'h0FF0) begin fails++; $display("FAIL bp_head1 got %h exp 0ff0", out_data); end
    in_op = 3'b111; in_a = 16'hBEEF; in_b = 16'h0000;
    @(negedge clk);
    checks++; if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 16'h0FF0})
      begin fails++; $display("FAIL bp_hold got rdy=%b v=%b %h exp rdy=0 v=1 0ff0", in_ready, out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({in_ready, out_data} !== {1'b1, 16'h1111})
      begin fails++; $display("FAIL bp_pop1 got rdy=%b %h exp rdy=1 1111", in_ready, out_data); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_data} !== {1'b1, 16'hBEEF})
      begin fails++; $display("FAIL bp_third got v=%b %h exp v=1 beef", out_valid, out_data); end
    @(negedge clk);
    checks++; if ({out_valid, out_data, out_zr, out_ng} !== 19'h0)
      begin fails++; $display("FAIL bp_drained got v=%b %h zr=%b ng=%b exp all 0", out_valid, out_data, out_zr, out_ng); end
  endtask

  task automatic test_streaming();
    int bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'b011; in_b = 16'hA5A5; in_a = 16'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'(i - 1) ^ 16'hA5A5}) begin
        fails++; bad++;
        $display("FAIL stream_%0d got rdy=%b v=%b %h exp rdy=1 v=1 %h", i, in_ready, out_valid, out_data, 16'(i - 1) ^ 16'hA5A5);
      end
      if (i < 20) in_a = 16'(i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end got v=%b exp 0 (%0d earlier errors)", out_valid, bad); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'b001, 16'hFFFF, 16'h1234);
    drive(3'b111, 16'h8000, 16'h0000);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rm_full got rdy=%b exp 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_data, in_ready} !== 18'h0)
      begin fails++; $display("FAIL rm_async got v=%b %h rdy=%b exp all 0", out_valid, out_data, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10)
      begin fails++; $display("FAIL rm_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    out_ready = 1'b1;
    drive(3'b101, 16'h0F0F, 16'h00F0);
    checks++; if ({out_valid, out_data, out_zr, out_ng} !== {1'b1, 16'hF000, 1'b0, 1'b1})
      begin fails++; $display("FAIL rm_after got v=%b %h zr=%b ng=%b exp v=1 f000 zr=0 ng=1", out_valid, out_data, out_zr, out_ng); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_no_ghost got v=%b exp 0", out_valid); end
  endtask

  task automatic test_param();
    logic [7:0] av [4];
    logic [7:0] ev [4];
    av[0] = 8'h80; av[1] = 8'h01; av[2] = 8'hFF; av[3] = 8'h00;
    ev[0] = 8'h7F; ev[1] = 8'hFE; ev[2] = 8'h00; ev[3] = 8'hFF;
    out_ready2 = 1'b0;
    in_op2 = 3'b000; in_b2 = 8'h33;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1; in_a2 = av[i];
      @(negedge clk);
      checks++; if (in_ready2 !== (i < 3))
        begin fails++; $display("FAIL p_ready_%0d got %b exp %b", i, in_ready2, (i < 3)); end
    end
    in_a2 = 8'h55;
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++; if ({out_valid2, out_data2, out_zr2, out_ng2} !== {1'b1, 8'h7F, 1'b0, 1'b0})
      begin fails++; $display("FAIL p_head got v=%b %h zr=%b ng=%b exp v=1 7f zr=0 ng=0", out_valid2, out_data2, out_zr2, out_ng2); end
    out_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({out_valid2, out_data2, out_zr2, out_ng2} !== {1'b1, ev[i], (ev[i] == 8'h00), ev[i][7]})
        begin fails++; $display("FAIL p_drain_%0d got v=%b %h zr=%b ng=%b exp %h", i, out_valid2, out_data2, out_zr2, out_ng2, ev[i]); end
      @(negedge clk);
    end
    checks++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL p_empty got v=%b exp 0", out_valid2); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_op = 3'b0; in_a = '0; in_b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_op2 = 3'b0; in_a2 = '0; in_b2 = '0;
    test_reset();
    test_not();
    test_all_ops();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
